// File: rtl/l2_if_pkg.sv
// Shared L1->L2 request encodings and issue-FSM state type.
package l2_if_pkg;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_NONE  = 2'b00;
    localparam cmd_t CMD_READ  = 2'b01;
    localparam cmd_t CMD_WRITE = 2'b10;
    localparam cmd_t CMD_RWIM  = 2'b11;

    localparam int DEF_ADDR_W = 26;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } iss_state_t;

endpackage

// File: rtl/l2_req_fifo.sv
// Circular request store with wrap-bit pointers; exposes head and tail entries.
module l2_req_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 28
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             head,
    output logic [W-1:0]             tail,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, tail_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: nothing reads it unless count says it is live.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr[IDX_W-1:0]] <= wdata;
    end

    assign tail_ptr = wr_ptr - 1'b1;
    assign head     = mem[rd_ptr[IDX_W-1:0]];
    assign tail     = mem[tail_ptr[IDX_W-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                      (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign count    = wr_ptr - rd_ptr;

endmodule

// File: rtl/l2_request_queue.sv
// L1->L2 request queue: write merging, overflow drop, valid/ready issue, statistics.
module l2_request_queue
    import l2_if_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [1:0]              cmd_in,
    input  logic [ADDR_W-1:0]       add_in,
    input  logic                    l2_ready,
    output logic                    l2_valid,
    output logic [1:0]              l2_cmd,
    output logic [ADDR_W-1:0]       l2_add,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic [CNT_W-1:0]        issued_cnt,
    output logic [CNT_W-1:0]        merged_cnt,
    output logic [CNT_W-1:0]        dropped_cnt
);

    localparam int W     = ADDR_W + 2;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    iss_state_t  state, state_nx;
    logic [W-1:0] head, tail;
    cmd_t        head_cmd, tail_cmd;
    logic        req, pop, merge, drop, enq, sole_completing;

    l2_req_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (enq),
        .pop   (pop),
        .wdata ({cmd_in, add_in}),
        .head  (head),
        .tail  (tail),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign head_cmd = head[W-1 -: 2];
    assign tail_cmd = tail[W-1 -: 2];

    assign req = (cmd_in != CMD_NONE);
    assign pop = l2_valid && l2_ready;
    // With one entry the tail is the head; if it is leaving, a merge would be lost.
    assign sole_completing = pop && (count == ONE);

    assign merge = req && (cmd_in == CMD_WRITE) && !empty && (tail_cmd == CMD_WRITE) &&
                   (tail[ADDR_W-1:0] == add_in) && !sole_completing;
    assign drop  = req && !merge && full && !pop;
    assign enq   = req && !merge && !drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        state <= ST_IDLE;
        else if (clear) state <= ST_IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (enq) state_nx = ST_ISSUE;
            ST_ISSUE: if (sole_completing && !enq) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    assign l2_valid = (state == ST_ISSUE);
    assign l2_cmd   = l2_valid ? head_cmd : CMD_NONE;
    assign l2_add   = l2_valid ? head[ADDR_W-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_cnt  <= '0;
            merged_cnt  <= '0;
            dropped_cnt <= '0;
        end else if (clear) begin
            issued_cnt  <= '0;
            merged_cnt  <= '0;
            dropped_cnt <= '0;
        end else begin
            if (pop)   issued_cnt  <= issued_cnt + 1'b1;
            if (merge) merged_cnt  <= merged_cnt + 1'b1;
            if (drop)  dropped_cnt <= dropped_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_l2_request_queue.sv
// Randomised + directed bench for l2_request_queue against a queue-based reference model.
module tb_l2_request_queue;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 26;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic [1:0]        cmd_in;
    logic [ADDR_W-1:0] add_in;
    logic              l2_ready;
    logic              l2_valid;
    logic [1:0]        l2_cmd;
    logic [ADDR_W-1:0] l2_add;
    logic              full, empty;
    logic [3:0]        count;
    logic [CNT_W-1:0]  issued_cnt, merged_cnt, dropped_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: list of pending {cmd, addr} plus event tallies.
    logic [27:0] q[$];
    int unsigned m_issued, m_merged, m_dropped, m_total;

    always #5 clk = ~clk;

    l2_request_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .clear(clear), .cmd_in(cmd_in), .add_in(add_in),
        .l2_ready(l2_ready), .l2_valid(l2_valid), .l2_cmd(l2_cmd), .l2_add(l2_add),
        .full(full), .empty(empty), .count(count), .issued_cnt(issued_cnt),
        .merged_cnt(merged_cnt), .dropped_cnt(dropped_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_issued = 0; m_merged = 0; m_dropped = 0; m_total = 0;
    endtask

    task automatic check_outputs();
        logic [27:0] h;
        h = (q.size() > 0) ? q[0] : 28'h0;
        chk("l2_valid", l2_valid, q.size() > 0);
        chk("l2_cmd",   l2_cmd,   h[27:26]);
        chk("l2_add",   l2_add,   h[25:0]);
        chk("count",    count,    q.size());
        chk("full",     full,     q.size() == DEPTH);
        chk("empty",    empty,    q.size() == 0);
        chk("issued",   issued_cnt,  m_issued);
        chk("merged",   merged_cnt,  m_merged);
        chk("dropped",  dropped_cnt, m_dropped);
        chk("invariant", 64'(issued_cnt) + merged_cnt + dropped_cnt + count, m_total);
    endtask

    task automatic model_update(input logic [1:0] c, input logic [25:0] a,
                                input logic r, input logic cl);
        bit pop, mrg, drp;
        if (cl) begin
            model_reset();
            return;
        end
        pop = (q.size() > 0) && r;
        mrg = 0; drp = 0;
        if (c != 2'b00) begin
            m_total++;
            if (c == 2'b10 && q.size() > 0 && q[$] == {2'b10, a} && !(pop && q.size() == 1))
                mrg = 1;
            else if (q.size() == DEPTH && !pop)
                drp = 1;
        end
        if (pop) begin void'(q.pop_front()); m_issued++; end
        if (mrg) m_merged++;
        if (drp) m_dropped++;
        if (c != 2'b00 && !mrg && !drp) q.push_back({c, a});
    endtask

    task automatic step(input logic [1:0] c, input logic [25:0] a, input logic r, input logic cl);
        @(negedge clk);
        cmd_in = c; add_in = a; l2_ready = r; clear = cl;
        #1 check_outputs();
        @(posedge clk);
        model_update(c, a, r, cl);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"},  l2_valid, 0);
        chk({tag, "_cmd"},    l2_cmd, 0);
        chk({tag, "_add"},    l2_add, 0);
        chk({tag, "_count"},  count, 0);
        chk({tag, "_empty"},  empty, 1);
        chk({tag, "_full"},   full, 0);
        chk({tag, "_issued"}, issued_cnt, 0);
        chk({tag, "_merged"}, merged_cnt, 0);
        chk({tag, "_drop"},   dropped_cnt, 0);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; cmd_in = 2'b00; add_in = '0; l2_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 check_reset_values("rst0");
        rst = 1'b0;

        // 1: single read, ready high
        step(2'b01, 26'h0000123, 1'b1, 1'b0);
        step(2'b00, 26'h0, 1'b1, 1'b0);
        step(2'b00, 26'h0, 1'b0, 1'b0);
        chk("t1_issued", issued_cnt, 1);
        chk("t1_empty", empty, 1);

        // 2: three same-line writes merge into one entry
        for (int i = 0; i < 3; i++) step(2'b10, 26'h00000AA, 1'b0, 1'b0);
        step(2'b00, 26'h0, 1'b0, 1'b0);
        chk("t2_count", count, 1);
        chk("t2_merged", merged_cnt, 2);
        step(2'b00, 26'h0, 1'b1, 1'b0);
        step(2'b00, 26'h0, 1'b0, 1'b0);
        chk("t2_issued", issued_cnt, 2);

        // 3: overflow by one, then drain in order
        step(2'b00, 26'h0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step(2'b01, 26'(100 + i), 1'b0, 1'b0);
        step(2'b00, 26'h0, 1'b0, 1'b0);
        chk("t3_full", full, 1);
        chk("t3_dropped", dropped_cnt, 1);

        // 4: push + pop while full
        step(2'b11, 26'h0000777, 1'b1, 1'b0);
        step(2'b00, 26'h0, 1'b0, 1'b0);
        chk("t4_count", count, 8);
        chk("t4_dropped", dropped_cnt, 1);
        for (int i = 0; i < 9; i++) step(2'b00, 26'h0, 1'b1, 1'b0);
        chk("t4_issued", issued_cnt, 9);

        // 5: write to a departing sole entry is not merged
        step(2'b00, 26'h0, 1'b0, 1'b1);
        step(2'b10, 26'h55, 1'b0, 1'b0);
        step(2'b10, 26'h55, 1'b1, 1'b0);
        step(2'b00, 26'h0, 1'b1, 1'b0);
        step(2'b00, 26'h0, 1'b0, 1'b0);
        chk("t5_issued", issued_cnt, 2);
        chk("t5_merged", merged_cnt, 0);

        // 6a: asynchronous reset while valid
        step(2'b01, 26'h11, 1'b0, 1'b0);
        step(2'b10, 26'h22, 1'b0, 1'b0);
        step(2'b00, 26'h0, 1'b0, 1'b0);
        @(negedge clk);
        cmd_in = 2'b00; l2_ready = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_values("arst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // 6b: clear while pushing
        step(2'b01, 26'h33, 1'b0, 1'b0);
        step(2'b01, 26'h34, 1'b0, 1'b0);
        step(2'b10, 26'h35, 1'b1, 1'b1);
        step(2'b00, 26'h0, 1'b0, 1'b0);
        chk("t6_count", count, 0);

        // Random traffic: low-ready phase fills the queue, high-ready phase drains it
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] c;
            logic r, cl;
            c  = 2'($urandom_range(0, 3));
            r  = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cl = ($urandom_range(0, 299) == 0);
            step(c, 26'($urandom_range(0, 3)), r, cl);
        end
        step(2'b00, 26'h0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
